// File: rtl/rx_ingress_frame_filter_pkg.sv
// Shared definitions for the ingress frame filter.
// Holds the write-FSM state encoding, the drop counter width and
// a saturating increment helper for the drop counters.
package rx_ingress_frame_filter_pkg;

    localparam int unsigned DROP_CNT_WIDTH = 16;
    localparam int unsigned FSM_WIDTH      = 2;

    localparam logic [FSM_WIDTH-1:0] ST_IDLE = 2'd0;
    localparam logic [FSM_WIDTH-1:0] ST_PASS = 2'd1;
    localparam logic [FSM_WIDTH-1:0] ST_DROP = 2'd2;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (v == {DROP_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_meta_sync_fifo.sv
// Single-clock show-ahead FIFO for per-frame metadata words.
// Ports: clk_i/rst_i (async active-high), wr_en_i/wr_data_i push side,
// rd_en_i/rd_data_o pop side (rd_data_o is the head entry), full_o/empty_o flags.
// Writes while full and reads while empty are ignored.
module rx_meta_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rx_ingress_frame_filter.sv
// Ingress frame filter: buffers each incoming frame and releases it only
// once its last beat shows a good CRC. Bad-CRC frames and frames that do
// not fit (buffer or metadata FIFO full) are rolled back and counted.
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_mac_Ingress_*               ingress data (MSB of data = crcerr on last beat)
//   i_Ingress_metadata*           ingress metadata, one beat per frame
//   o_filt_axi_*                  committed frame beats
//   o_filt_metadata*              metadata of committed frames, in frame order
//   o_crc_drop_cnt/o_ovf_drop_cnt saturating drop counters
module rx_ingress_frame_filter
    import rx_ingress_frame_filter_pkg::*;
#(
    parameter int unsigned CROSS_DATA_WIDTH = 32,
    parameter int unsigned METADATA_WIDTH   = 64,
    parameter int unsigned DATA_DEPTH       = 512,
    parameter int unsigned META_DEPTH       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CROSS_DATA_WIDTH:0]     i_mac_Ingress_port_axi_data,
    input  logic [CROSS_DATA_WIDTH/8-1:0] i_mac_Ingress_axi_data_keep,
    input  logic                          i_mac_Ingress_axi_data_valid,
    input  logic                          i_mac_Ingress_axi_data_last,
    output logic                          o_mac_Ingress_axi_data_ready,
    input  logic [METADATA_WIDTH-1:0]     i_Ingress_metadata,
    input  logic                          i_Ingress_metadata_valid,
    input  logic                          i_Ingress_metadata_last,
    output logic                          o_Ingress_metadata_ready,
    output logic [CROSS_DATA_WIDTH-1:0]   o_filt_axi_data,
    output logic [CROSS_DATA_WIDTH/8-1:0] o_filt_axi_keep,
    output logic                          o_filt_axi_valid,
    output logic                          o_filt_axi_last,
    input  logic                          i_filt_axi_ready,
    output logic [METADATA_WIDTH-1:0]     o_filt_metadata,
    output logic                          o_filt_metadata_valid,
    input  logic                          i_filt_metadata_ready,
    output logic [15:0]                   o_crc_drop_cnt,
    output logic [15:0]                   o_ovf_drop_cnt
);

    localparam int unsigned KW    = CROSS_DATA_WIDTH / 8;
    localparam int unsigned AW    = $clog2(DATA_DEPTH);
    localparam int unsigned RAM_W = CROSS_DATA_WIDTH + KW + 1;

    logic [FSM_WIDTH-1:0]      state_q, state_d;
    logic [AW:0]               wr_ptr_q, wr_ptr_d;
    logic [AW:0]               commit_ptr_q, commit_ptr_d;
    logic [AW:0]               rd_ptr_q;
    logic                      stg_valid_q;
    logic [METADATA_WIDTH-1:0] stg_data_q;
    logic                      rst_done_q;
    logic [DROP_CNT_WIDTH-1:0] crc_cnt_q, ovf_cnt_q;
    logic                      crc_inc, ovf_inc, stg_clr, meta_push, ram_we;
    logic                      in_meta, in_beat, crcerr, buf_full;
    logic                      meta_full, meta_empty;
    logic [METADATA_WIDTH-1:0] meta_rd_data;

    logic [RAM_W-1:0]          mem [DATA_DEPTH];
    logic                      s1_valid_q;
    logic [RAM_W-1:0]          s1_word_q;
    logic                      out_load, rd_en;

    // rst_done_q keeps metadata ready low while reset is held.
    assign o_Ingress_metadata_ready     = rst_done_q && !stg_valid_q;
    // DROP sinks the tail of a frame whose metadata is already discarded, so
    // it needs no staged metadata. A beat arriving on a full buffer is taken
    // and triggers the overflow drop instead of stalling the MAC.
    assign o_mac_Ingress_axi_data_ready = (state_q == ST_DROP) || stg_valid_q;

    assign in_meta  = i_Ingress_metadata_valid && o_Ingress_metadata_ready;
    assign in_beat  = i_mac_Ingress_axi_data_valid && o_mac_Ingress_axi_data_ready;
    assign crcerr   = i_mac_Ingress_port_axi_data[CROSS_DATA_WIDTH];
    assign buf_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        crc_inc      = 1'b0;
        ovf_inc      = 1'b0;
        stg_clr      = 1'b0;
        meta_push    = 1'b0;
        ram_we       = 1'b0;
        if (in_beat) begin
            case (state_q)
                ST_DROP: begin
                    if (i_mac_Ingress_axi_data_last) state_d = ST_IDLE;
                end
                default: begin
                    if (buf_full) begin
                        wr_ptr_d = commit_ptr_q;
                        stg_clr  = 1'b1;
                        ovf_inc  = 1'b1;
                        state_d  = i_mac_Ingress_axi_data_last ? ST_IDLE : ST_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = ST_PASS;
                        if (i_mac_Ingress_axi_data_last) begin
                            state_d = ST_IDLE;
                            stg_clr = 1'b1;
                            if (crcerr) begin
                                wr_ptr_d = commit_ptr_q;
                                crc_inc  = 1'b1;
                            end else if (meta_full) begin
                                wr_ptr_d = commit_ptr_q;
                                ovf_inc  = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                meta_push    = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            stg_valid_q  <= 1'b0;
            stg_data_q   <= '0;
            rst_done_q   <= 1'b0;
            crc_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rst_done_q   <= 1'b1;
            if (stg_clr) begin
                stg_valid_q <= 1'b0;
            end else if (in_meta && i_Ingress_metadata_last) begin
                // Only the closing metadata beat is kept for the frame.
                stg_valid_q <= 1'b1;
                stg_data_q  <= i_Ingress_metadata;
            end
            if (crc_inc) crc_cnt_q <= sat_inc(crc_cnt_q);
            if (ovf_inc) ovf_cnt_q <= sat_inc(ovf_cnt_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {i_mac_Ingress_port_axi_data[CROSS_DATA_WIDTH-1:0],
                                      i_mac_Ingress_axi_data_keep, i_mac_Ingress_axi_data_last};
        end
    end

    // Two-stage read: registered RAM output (s1) then the output register.
    // A read is issued only when s1 is free or moves on this cycle.
    assign out_load = !o_filt_axi_valid || i_filt_axi_ready;
    assign rd_en    = (rd_ptr_q != commit_ptr_q) && (!s1_valid_q || out_load);

    always_ff @(posedge i_clk) begin
        if (rd_en) s1_word_q <= mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q         <= '0;
            s1_valid_q       <= 1'b0;
            o_filt_axi_valid <= 1'b0;
            o_filt_axi_data  <= '0;
            o_filt_axi_keep  <= '0;
            o_filt_axi_last  <= 1'b0;
        end else begin
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_en) begin
                s1_valid_q <= 1'b1;
            end else if (out_load) begin
                s1_valid_q <= 1'b0;
            end
            if (out_load) begin
                o_filt_axi_valid <= s1_valid_q;
                if (s1_valid_q) begin
                    {o_filt_axi_data, o_filt_axi_keep, o_filt_axi_last} <= s1_word_q;
                end
            end
        end
    end

    rx_meta_sync_fifo #(
        .WIDTH(METADATA_WIDTH),
        .DEPTH(META_DEPTH)
    ) u_meta_fifo (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .wr_en_i  (meta_push),
        .wr_data_i(stg_data_q),
        .rd_en_i  (o_filt_metadata_valid && i_filt_metadata_ready),
        .rd_data_o(meta_rd_data),
        .full_o   (meta_full),
        .empty_o  (meta_empty)
    );

    assign o_filt_metadata_valid = !meta_empty;
    assign o_filt_metadata       = meta_empty ? '0 : meta_rd_data;
    assign o_crc_drop_cnt        = crc_cnt_q;
    assign o_ovf_drop_cnt        = ovf_cnt_q;

endmodule

// File: tb/tb_rx_ingress_frame_filter.sv
`timescale 1ns/1ps
module tb_rx_ingress_frame_filter;

    localparam int CDW = 32;
    localparam int MW  = 64;
    localparam int DD  = 8;
    localparam int MD  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [CDW:0]  i_mac_Ingress_port_axi_data = '0;
    logic [3:0]    i_mac_Ingress_axi_data_keep = '0;
    logic          i_mac_Ingress_axi_data_valid = 1'b0;
    logic          i_mac_Ingress_axi_data_last = 1'b0;
    logic          o_mac_Ingress_axi_data_ready;
    logic [MW-1:0] i_Ingress_metadata = '0;
    logic          i_Ingress_metadata_valid = 1'b0;
    logic          i_Ingress_metadata_last = 1'b0;
    logic          o_Ingress_metadata_ready;
    logic [31:0]   o_filt_axi_data;
    logic [3:0]    o_filt_axi_keep;
    logic          o_filt_axi_valid;
    logic          o_filt_axi_last;
    logic          i_filt_axi_ready;
    logic [MW-1:0] o_filt_metadata;
    logic          o_filt_metadata_valid;
    logic          i_filt_metadata_ready = 1'b1;
    logic [15:0]   o_crc_drop_cnt;
    logic [15:0]   o_ovf_drop_cnt;

    rx_ingress_frame_filter #(
        .CROSS_DATA_WIDTH(CDW),
        .METADATA_WIDTH  (MW),
        .DATA_DEPTH      (DD),
        .META_DEPTH      (MD)
    ) dut (
        .i_clk                       (i_clk),
        .i_rst                       (i_rst),
        .i_mac_Ingress_port_axi_data (i_mac_Ingress_port_axi_data),
        .i_mac_Ingress_axi_data_keep (i_mac_Ingress_axi_data_keep),
        .i_mac_Ingress_axi_data_valid(i_mac_Ingress_axi_data_valid),
        .i_mac_Ingress_axi_data_last (i_mac_Ingress_axi_data_last),
        .o_mac_Ingress_axi_data_ready(o_mac_Ingress_axi_data_ready),
        .i_Ingress_metadata          (i_Ingress_metadata),
        .i_Ingress_metadata_valid    (i_Ingress_metadata_valid),
        .i_Ingress_metadata_last     (i_Ingress_metadata_last),
        .o_Ingress_metadata_ready    (o_Ingress_metadata_ready),
        .o_filt_axi_data             (o_filt_axi_data),
        .o_filt_axi_keep             (o_filt_axi_keep),
        .o_filt_axi_valid            (o_filt_axi_valid),
        .o_filt_axi_last             (o_filt_axi_last),
        .i_filt_axi_ready            (i_filt_axi_ready),
        .o_filt_metadata             (o_filt_metadata),
        .o_filt_metadata_valid       (o_filt_metadata_valid),
        .i_filt_metadata_ready       (i_filt_metadata_ready),
        .o_crc_drop_cnt              (o_crc_drop_cnt),
        .o_ovf_drop_cnt              (o_ovf_drop_cnt)
    );

    always #2 i_clk = ~i_clk;

    int n_total = 0;
    int n_pass  = 0;

    beat_t       exp_q[$];
    logic [63:0] exp_meta[$];

    // 0: ready high, 1: ready low, 2: ready toggles every cycle
    int   rdy_mode = 0;
    logic tog = 1'b0;
    always @(posedge i_clk) tog <= ~tog;
    assign i_filt_axi_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? 1'b0 : tog);

    logic        prev_stall = 1'b0;
    beat_t       held;
    beat_t       got_b;
    beat_t       exp_b;
    logic [63:0] exp_m;

    always @(negedge i_clk) begin
        got_b = {o_filt_axi_data, o_filt_axi_keep, o_filt_axi_last};
        if (prev_stall) begin
            n_total++;
            if (o_filt_axi_valid === 1'b1 && got_b === held) n_pass++;
            else $display("FAIL stall_hold: valid=%b beat=%h, required valid=1 beat=%h",
                          o_filt_axi_valid, got_b, held);
        end
        if (o_filt_axi_valid === 1'b1 && i_filt_axi_ready === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL data_out: unexpected beat %h, no beat required", got_b);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_b === exp_b) n_pass++;
                else $display("FAIL data_out: beat %h, required %h", got_b, exp_b);
            end
        end
        prev_stall = (o_filt_axi_valid === 1'b1) && (i_filt_axi_ready === 1'b0);
        held       = got_b;
        if (o_filt_metadata_valid === 1'b1 && i_filt_metadata_ready === 1'b1) begin
            n_total++;
            if (exp_meta.size() == 0) begin
                $display("FAIL meta_out: unexpected metadata %h, none required", o_filt_metadata);
            end else begin
                exp_m = exp_meta.pop_front();
                if (o_filt_metadata === exp_m) n_pass++;
                else $display("FAIL meta_out: metadata %h, required %h", o_filt_metadata, exp_m);
            end
        end
    end

    task automatic send_frame(input int nbeats, input logic crc, input logic [7:0] tag,
                              input logic good, input int stop_after, output int stalls);
        logic [63:0] m;
        beat_t       b;
        int          t;
        stalls = 0;
        m = {8'h00, tag, 48'hC0DE_0000_BEEF};
        if (good) exp_meta.push_back(m);
        i_Ingress_metadata       = m;
        i_Ingress_metadata_valid = 1'b1;
        i_Ingress_metadata_last  = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge i_clk);
            if (o_Ingress_metadata_ready) break;
        end
        if (t == 100) begin
            n_total++;
            $display("FAIL meta_handshake: ready low for %0d cycles, required high", t);
        end
        @(posedge i_clk); #1;
        i_Ingress_metadata_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == stop_after) break;
            b.last = (i == nbeats - 1);
            b.data = {tag, 8'h5A, 16'(i)};
            b.keep = b.last ? {1'b0, tag[0], 2'b11} : 4'hF;
            i_mac_Ingress_port_axi_data  = {crc & b.last, b.data};
            i_mac_Ingress_axi_data_keep  = b.keep;
            i_mac_Ingress_axi_data_last  = b.last;
            i_mac_Ingress_axi_data_valid = 1'b1;
            for (t = 0; t < 100; t++) begin
                @(negedge i_clk);
                if (o_mac_Ingress_axi_data_ready) break;
            end
            if (t == 100) begin
                n_total++;
                $display("FAIL data_handshake: ready low for %0d cycles, required high", t);
            end else begin
                stalls += t;
            end
            @(posedge i_clk); #1;
            if (good) exp_q.push_back(b);
        end
        i_mac_Ingress_axi_data_valid = 1'b0;
        i_mac_Ingress_axi_data_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        for (t = 0; t < 300; t++) begin
            if (exp_q.size() == 0 && exp_meta.size() == 0) break;
            @(posedge i_clk); #1;
        end
        n_total++;
        if (t < 300) n_pass++;
        else $display("FAIL %s_drain: %0d beats and %0d metadata still owed, required 0",
                      name, exp_q.size(), exp_meta.size());
        repeat (6) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_total++;
        if ({o_mac_Ingress_axi_data_ready, o_Ingress_metadata_ready, o_filt_axi_valid,
             o_filt_axi_last, o_filt_metadata_valid} === 5'b0) n_pass++;
        else $display("FAIL reset_ctrl: ctrl=%b, required 00000",
                      {o_mac_Ingress_axi_data_ready, o_Ingress_metadata_ready, o_filt_axi_valid,
                       o_filt_axi_last, o_filt_metadata_valid});
        n_total++;
        if ({o_filt_axi_data, o_filt_axi_keep} === 36'h0) n_pass++;
        else $display("FAIL reset_data: data=%h keep=%h, required 0", o_filt_axi_data,
                      o_filt_axi_keep);
        n_total++;
        if ({o_crc_drop_cnt, o_ovf_drop_cnt} === 32'h0) n_pass++;
        else $display("FAIL reset_cnt: crc=%h ovf=%h, required 0", o_crc_drop_cnt, o_ovf_drop_cnt);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_total++;
        if (o_Ingress_metadata_ready === 1'b1) n_pass++;
        else $display("FAIL reset_release: meta ready=%b, required 1", o_Ingress_metadata_ready);
    endtask

    task automatic test_basic();
        int st;
        send_frame(4, 1'b0, 8'hA0, 1'b1, -1, st);
        @(posedge i_clk); #1;
        n_total++;
        if (o_filt_axi_valid === 1'b0) n_pass++;
        else $display("FAIL basic_latency1: valid=%b, required 0", o_filt_axi_valid);
        @(posedge i_clk); #1;
        n_total++;
        if (o_filt_axi_valid === 1'b1) n_pass++;
        else $display("FAIL basic_latency2: valid=%b, required 1", o_filt_axi_valid);
        drain("basic");
        n_total++;
        if (st == 0 && o_crc_drop_cnt === 16'd0 && o_ovf_drop_cnt === 16'd0) n_pass++;
        else $display("FAIL basic_cnt: stalls=%0d crc=%0d ovf=%0d, required 0 0 0", st,
                      o_crc_drop_cnt, o_ovf_drop_cnt);
    endtask

    task automatic test_crc_drop();
        int st;
        send_frame(3, 1'b1, 8'hB1, 1'b0, -1, st);
        send_frame(2, 1'b0, 8'hB2, 1'b1, -1, st);
        drain("crc");
        n_total++;
        if (o_crc_drop_cnt === 16'd1 && o_ovf_drop_cnt === 16'd0) n_pass++;
        else $display("FAIL crc_cnt: crc=%0d ovf=%0d, required 1 0", o_crc_drop_cnt,
                      o_ovf_drop_cnt);
    endtask

    task automatic test_overflow();
        int st;
        rdy_mode = 1;
        send_frame(10, 1'b0, 8'hC1, 1'b0, -1, st);
        n_total++;
        if (st == 0) n_pass++;
        else $display("FAIL ovf_ready: %0d stall cycles, required 0", st);
        n_total++;
        if (o_ovf_drop_cnt === 16'd1 && o_crc_drop_cnt === 16'd1) n_pass++;
        else $display("FAIL ovf_cnt: ovf=%0d crc=%0d, required 1 1", o_ovf_drop_cnt,
                      o_crc_drop_cnt);
        rdy_mode = 0;
        send_frame(4, 1'b0, 8'hC2, 1'b1, -1, st);
        drain("ovf");
    endtask

    task automatic test_backpressure();
        int st;
        rdy_mode = 2;
        send_frame(6, 1'b0, 8'hD1, 1'b1, -1, st);
        drain("bp");
        rdy_mode = 0;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        int st;
        send_frame(5, 1'b0, 8'hE1, 1'b0, 2, st);
        i_rst = 1'b1;
        #1;
        n_total++;
        if ({o_mac_Ingress_axi_data_ready, o_Ingress_metadata_ready, o_filt_axi_valid,
             o_filt_axi_last, o_filt_metadata_valid} === 5'b0) n_pass++;
        else $display("FAIL midrst_ctrl: ctrl=%b, required 00000",
                      {o_mac_Ingress_axi_data_ready, o_Ingress_metadata_ready, o_filt_axi_valid,
                       o_filt_axi_last, o_filt_metadata_valid});
        n_total++;
        if ({o_crc_drop_cnt, o_ovf_drop_cnt, o_filt_axi_data, o_filt_axi_keep} === 68'h0) n_pass++;
        else $display("FAIL midrst_vals: crc=%h ovf=%h data=%h keep=%h, required 0",
                      o_crc_drop_cnt, o_ovf_drop_cnt, o_filt_axi_data, o_filt_axi_keep);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        send_frame(3, 1'b0, 8'hE2, 1'b1, -1, st);
        drain("midrst");
        n_total++;
        if (o_crc_drop_cnt === 16'd0 && o_ovf_drop_cnt === 16'd0) n_pass++;
        else $display("FAIL midrst_cnt: crc=%0d ovf=%0d, required 0 0", o_crc_drop_cnt,
                      o_ovf_drop_cnt);
    endtask

    task automatic test_crc_saturation();
        int st;
        for (int i = 0; i < 65537; i++) begin
            send_frame(1, 1'b1, 8'(i), 1'b0, -1, st);
            if (i == 65534) begin
                n_total++;
                if (o_crc_drop_cnt === 16'hFFFF) n_pass++;
                else $display("FAIL sat_reach: crc=%h after 65535 drops, required ffff",
                              o_crc_drop_cnt);
            end
            if (n_total - n_pass > 50) break;
        end
        n_total++;
        if (o_crc_drop_cnt === 16'hFFFF && o_ovf_drop_cnt === 16'd0) n_pass++;
        else $display("FAIL sat_hold: crc=%h ovf=%h, required ffff 0000", o_crc_drop_cnt,
                      o_ovf_drop_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_drop();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_crc_saturation();
        repeat (4) @(posedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
